// File: rtl/jk_register_pkg.sv
// Shared types and helpers for the jk_register datapath register.
// Operation selector and the per-bit JK next-state rule.
package jk_register_pkg;

    typedef enum logic [1:0] {
        OP_HOLD_JK,
        OP_INCREMENT,
        OP_LOAD,
        OP_CLEAR
    } jk_register_op_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            2'b00:   nxt = q;
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            default: nxt = ~q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_register_if.sv
// Control/bus bundle between the control unit (master) and a jk_register (slave).
interface jk_register_if #(
    parameter int WIDTH = 16
);
    logic             clear_in;
    logic             load_in;
    logic             increment_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] j_in;
    logic [WIDTH-1:0] k_in;
    logic [WIDTH-1:0] q_out;
    logic             carry_out;
    logic             overflow_out;

    modport master (
        output clear_in, load_in, increment_in, data_in, j_in, k_in,
        input  q_out, carry_out, overflow_out
    );

    modport slave (
        input  clear_in, load_in, increment_in, data_in, j_in, k_in,
        output q_out, carry_out, overflow_out
    );
endinterface

// File: rtl/jk_register_cell.sv
// Single register bit: JK flip-flop with a forced-value override and
// asynchronous active-low reset to RESET_BIT.
module jk_cell
    import jk_register_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic force_en_in,
    input  logic force_value_in,
    input  logic j_in,
    input  logic k_in,
    output logic q_out
);

    // The force path carries clear/load/increment; JK only acts when nothing is forced.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_out <= RESET_BIT;
        end else if (force_en_in) begin
            q_out <= force_value_in;
        end else begin
            q_out <= jk_next(q_out, j_in, k_in);
        end
    end

endmodule

// File: rtl/jk_register.sv
// WIDTH-bit basic-computer register built from jk_cell bits, adding
// clear, parallel load and increment with registered carry and sticky overflow.
module jk_register
    import jk_register_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic         clock,
    input  logic         reset_n,
    jk_register_if.slave bus
);

    jk_register_op_e  op;
    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] inc_value;
    logic [WIDTH-1:0] force_value;
    logic             force_en;
    logic             wrap;
    logic             carry_q;
    logic             overflow_q;

    always_comb begin
        op = OP_HOLD_JK;
        if (bus.clear_in) begin
            op = OP_CLEAR;
        end else if (bus.load_in) begin
            op = OP_LOAD;
        end else if (bus.increment_in) begin
            op = OP_INCREMENT;
        end
    end

    assign inc_value = q_bits + WIDTH'(1);
    assign wrap      = &q_bits;

    always_comb begin
        force_en    = 1'b1;
        force_value = '0;
        case (op)
            OP_CLEAR:     force_value = '0;
            OP_LOAD:      force_value = bus.data_in;
            OP_INCREMENT: force_value = inc_value;
            default:      force_en    = 1'b0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_cell (
            .clock          (clock),
            .reset_n        (reset_n),
            .force_en_in    (force_en),
            .force_value_in (force_value[i]),
            .j_in           (bus.j_in[i]),
            .k_in           (bus.k_in[i]),
            .q_out          (q_bits[i])
        );
    end

    // Carry pulses only on the edge that wraps; overflow remembers any wrap until cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (op)
                OP_CLEAR: begin
                    carry_q    <= 1'b0;
                    overflow_q <= 1'b0;
                end
                OP_INCREMENT: begin
                    carry_q    <= wrap;
                    overflow_q <= overflow_q | wrap;
                end
                default: carry_q <= 1'b0;
            endcase
        end
    end

    assign bus.q_out        = q_bits;
    assign bus.carry_out    = carry_q;
    assign bus.overflow_out = overflow_q;

endmodule

// File: tb/tb_jk_register.sv
// Bench for jk_register: directed scenarios on 4-bit and 1-bit instances plus
// a randomized run against an arithmetic reference model.
module tb_jk_register;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    jk_register_if #(.WIDTH(4)) bus4 ();
    jk_register_if #(.WIDTH(1)) bus1 ();

    jk_register #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    jk_register #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    // Called at a negedge: applies inputs, lets one rising edge pass, returns at the next negedge.
    task automatic apply_stimulus4(input logic clr, input logic ld, input logic inc,
                                   input logic [3:0] d, input logic [3:0] j, input logic [3:0] k);
        bus4.clear_in     = clr;
        bus4.load_in      = ld;
        bus4.increment_in = inc;
        bus4.data_in      = d;
        bus4.j_in         = j;
        bus4.k_in         = k;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_stimulus1(input logic inc, input logic j, input logic k);
        bus1.clear_in     = 1'b0;
        bus1.load_in      = 1'b0;
        bus1.increment_in = inc;
        bus1.data_in      = 1'b0;
        bus1.j_in         = j;
        bus1.k_in         = k;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus4.q_out !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL reset_q got %b expected %b", bus4.q_out, 4'b1010);
        end
        checks++;
        if (bus4.carry_out !== 1'b0 || bus4.overflow_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got c=%b o=%b expected c=0 o=0", bus4.carry_out, bus4.overflow_out);
        end
        checks++;
        if (bus1.q_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_q_w1 got %b expected 0", bus1.q_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_jk_mode();
        logic [3:0] jt  [5] = '{4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] kt  [5] = '{4'b0000, 4'b0101, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] exp [5] = '{4'b1111, 4'b1010, 4'b0101, 4'b1010, 4'b1010};
        apply_stimulus4(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        checks++;
        if (bus4.q_out !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL jk_clear got %b expected 0000", bus4.q_out);
        end
        for (int s = 0; s < 5; s++) begin
            apply_stimulus4(1'b0, 1'b0, 1'b0, 4'h0, jt[s], kt[s]);
            checks++;
            if (bus4.q_out !== exp[s] || bus4.carry_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL jk_step%0d got q=%b c=%b expected q=%b c=0", s, bus4.q_out, bus4.carry_out, exp[s]);
            end
        end
    endtask

    task automatic test_load_increment();
        logic [3:0] exp_q [3] = '{4'b1111, 4'b0000, 4'b0001};
        logic       exp_c [3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_o [3] = '{1'b0, 1'b1, 1'b1};
        apply_stimulus4(1'b0, 1'b1, 1'b0, 4'b1110, 4'h0, 4'h0);
        checks++;
        if (bus4.q_out !== 4'b1110 || bus4.overflow_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load got q=%b o=%b expected q=1110 o=0", bus4.q_out, bus4.overflow_out);
        end
        for (int s = 0; s < 3; s++) begin
            apply_stimulus4(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
            checks++;
            if (bus4.q_out !== exp_q[s] || bus4.carry_out !== exp_c[s] || bus4.overflow_out !== exp_o[s]) begin
                failures++;
                $display("[TB] FAIL inc_step%0d got q=%b c=%b o=%b expected q=%b c=%b o=%b", s,
                         bus4.q_out, bus4.carry_out, bus4.overflow_out, exp_q[s], exp_c[s], exp_o[s]);
            end
        end
        apply_stimulus4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        checks++;
        if (bus4.q_out !== 4'b0001 || bus4.carry_out !== 1'b0 || bus4.overflow_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_after_wrap got q=%b c=%b o=%b expected q=0001 c=0 o=1",
                     bus4.q_out, bus4.carry_out, bus4.overflow_out);
        end
    endtask

    task automatic test_priority();
        apply_stimulus4(1'b0, 1'b1, 1'b0, 4'b0110, 4'h0, 4'h0);
        apply_stimulus4(1'b1, 1'b1, 1'b1, 4'b1001, 4'b1111, 4'b1111);
        checks++;
        if (bus4.q_out !== 4'b0000 || bus4.overflow_out !== 1'b0 || bus4.carry_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prio_clear got q=%b c=%b o=%b expected q=0000 c=0 o=0",
                     bus4.q_out, bus4.carry_out, bus4.overflow_out);
        end
        apply_stimulus4(1'b0, 1'b1, 1'b1, 4'b0011, 4'b1111, 4'b1111);
        checks++;
        if (bus4.q_out !== 4'b0011) begin
            failures++;
            $display("[TB] FAIL prio_load got q=%b expected 0011", bus4.q_out);
        end
        // A load straight after a wrap must drop carry yet keep overflow.
        apply_stimulus4(1'b0, 1'b1, 1'b0, 4'b1111, 4'h0, 4'h0);
        apply_stimulus4(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        apply_stimulus4(1'b0, 1'b1, 1'b1, 4'b0101, 4'h0, 4'h0);
        checks++;
        if (bus4.q_out !== 4'b0101 || bus4.carry_out !== 1'b0 || bus4.overflow_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_after_wrap got q=%b c=%b o=%b expected q=0101 c=0 o=1",
                     bus4.q_out, bus4.carry_out, bus4.overflow_out);
        end
    endtask

    task automatic test_reset_mid_op();
        apply_stimulus4(1'b0, 1'b1, 1'b0, 4'b0111, 4'h0, 4'h0);
        bus4.load_in      = 1'b0;
        bus4.increment_in = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (bus4.q_out !== 4'b1010 || bus4.carry_out !== 1'b0 || bus4.overflow_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_reset got q=%b c=%b o=%b expected q=1010 c=0 o=0",
                     bus4.q_out, bus4.carry_out, bus4.overflow_out);
        end
        #4 reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (bus4.q_out !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL midop_suppressed got q=%b expected 1010", bus4.q_out);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus4.q_out !== 4'b1011 || bus4.carry_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_release got q=%b c=%b expected q=1011 c=0", bus4.q_out, bus4.carry_out);
        end
        bus4.increment_in = 1'b0;
    endtask

    task automatic test_width1();
        logic exp_t [3] = '{1'b1, 1'b0, 1'b1};
        logic exp_q [3] = '{1'b0, 1'b1, 1'b0};
        logic exp_c [3] = '{1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 3; s++) begin
            apply_stimulus1(1'b0, 1'b1, 1'b1);
            checks++;
            if (bus1.q_out !== exp_t[s]) begin
                failures++;
                $display("[TB] FAIL w1_toggle%0d got %b expected %b", s, bus1.q_out, exp_t[s]);
            end
        end
        for (int s = 0; s < 3; s++) begin
            apply_stimulus1(1'b1, 1'b0, 1'b0);
            checks++;
            if (bus1.q_out !== exp_q[s] || bus1.carry_out !== exp_c[s] || bus1.overflow_out !== 1'b1) begin
                failures++;
                $display("[TB] FAIL w1_inc%0d got q=%b c=%b o=%b expected q=%b c=%b o=1", s,
                         bus1.q_out, bus1.carry_out, bus1.overflow_out, exp_q[s], exp_c[s]);
            end
        end
        apply_stimulus1(1'b0, 1'b0, 1'b0);
    endtask

    // Reference model works on integers: modulo-16 counting and a per-bit rule table.
    task automatic test_random();
        int   m_q = 0;
        int   m_c = 0;
        int   m_o = 0;
        logic clr, ld, inc;
        logic [3:0] d, j, k;
        apply_stimulus4(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        for (int n = 0; n < 300; n++) begin
            clr = ($urandom_range(0, 15) == 0);
            ld  = ($urandom_range(0, 4) == 0);
            inc = ($urandom_range(0, 1) == 0);
            d   = 4'($urandom_range(0, 15));
            j   = 4'($urandom_range(0, 15));
            k   = 4'($urandom_range(0, 15));
            if (clr) begin
                m_q = 0; m_c = 0; m_o = 0;
            end else if (ld) begin
                m_q = int'(d); m_c = 0;
            end else if (inc) begin
                m_c = (m_q == 15) ? 1 : 0;
                m_q = (m_q + 1) % 16;
                if (m_c == 1) m_o = 1;
            end else begin
                int nq = 0;
                for (int b = 0; b < 4; b++) begin
                    int bit_now = (m_q >> b) % 2;
                    int bit_new = bit_now;
                    if (j[b] && k[b])  bit_new = 1 - bit_now;
                    else if (j[b])     bit_new = 1;
                    else if (k[b])     bit_new = 0;
                    nq = nq + bit_new * (1 << b);
                end
                m_q = nq;
                m_c = 0;
            end
            apply_stimulus4(clr, ld, inc, d, j, k);
            checks++;
            if (int'(bus4.q_out) != m_q || bus4.carry_out !== 1'(m_c) || bus4.overflow_out !== 1'(m_o)
                || $isunknown({bus4.q_out, bus4.carry_out, bus4.overflow_out})) begin
                failures++;
                $display("[TB] FAIL random%0d got q=%b c=%b o=%b expected q=%0d c=%0d o=%0d", n,
                         bus4.q_out, bus4.carry_out, bus4.overflow_out, m_q, m_c, m_o);
            end
        end
    endtask

    initial begin
        bus4.clear_in = 1'b0; bus4.load_in = 1'b0; bus4.increment_in = 1'b0;
        bus4.data_in  = '0;   bus4.j_in    = '0;   bus4.k_in         = '0;
        bus1.clear_in = 1'b0; bus1.load_in = 1'b0; bus1.increment_in = 1'b0;
        bus1.data_in  = '0;   bus1.j_in    = '0;   bus1.k_in         = '0;
        test_reset();
        test_jk_mode();
        test_load_increment();
        test_priority();
        test_reset_mid_op();
        test_width1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_register.md
Name: jk_register

Overview:
- Parametrised WIDTH-bit register built from per-bit JK cells; next generation of the single JK flip-flop.
- Adds to per-bit JK control:
  - asynchronous reset to a parameter value;
  - synchronous clear, parallel load and increment, as required by the basic-computer registers (AR, PC, DR, AC, TR).
- Sits in the datapath; driven by control-unit decode lines and the common bus.

Parameters:
- WIDTH, 16, register width in bits (>= 1).
- RESET_VALUE, '0, WIDTH-bit value loaded on asynchronous reset.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear_in  input  1  synchronous clear to zero.
- load_in  input  1  synchronous parallel load from data_in.
- increment_in  input  1  synchronous +1 (modulo 2^WIDTH).
- data_in  input  WIDTH  parallel load data (bus).
- j_in  input  WIDTH  per-bit J (set) inputs.
- k_in  input  WIDTH  per-bit K (reset) inputs.
- q_out  output  WIDTH  register contents.
- carry_out  output  1  registered; 1 for one cycle after an increment wrapped all-ones to zero.
- overflow_out  output  1  sticky; set on any wrap, cleared only by clear_in or reset.

Behaviour:
- Reset: reset_n low asynchronously forces q_out=RESET_VALUE, carry_out=0 and overflow_out=0, regardless of clock. Held while low. The first rising edge after release performs normal operation.
- All other updates occur on the rising edge of clock. Outputs are stable by the following negedge, where benches sample.
- Operation priority, one operation per edge; mode encoded as an enum:
  - 1. clear_in=1: q=0, carry=0, overflow=0. load_in, increment_in and j/k are ignored.
  - 2. else load_in=1: q=data_in, carry=0, overflow unchanged. increment_in and j/k are ignored.
  - 3. else increment_in=1: q=q+1, truncated to WIDTH. carry=1 iff old q is all-ones; overflow |= carry. j/k are ignored.
  - 4. else JK mode, per bit i:
    - j=0,k=0: hold.
    - j=1,k=0: set to 1.
    - j=0,k=1: reset to 0.
    - j=1,k=1: toggle.
    - carry=0, overflow unchanged.
- JK mode applies all bits independently in the same edge.
- No operation active and j=k=0: full hold, carry_out drops to 0.
- carry_out is a one-cycle pulse. Consecutive wrapping increments produce consecutive pulses; this needs WIDTH=1 or a reload.
- WIDTH=1: increment equals toggle; carry=1 when old q=1.
- X-safety: no latches. Every output has a defined value after reset. No combinational path from inputs to outputs.

Decomposition:
- Package jk_register_pkg holds:
  - typedef enum jk_register_op_e {OP_HOLD_JK, OP_INCREMENT, OP_LOAD, OP_CLEAR};
  - function jk_next(q, j, k) returning the JK next-state bit.
- Sub-module jk_cell: one bit with async active-low reset to a RESET_BIT parameter.
  - Inputs: force_en_in and force_value_in (used by clear/load/increment), plus j_in and k_in.
  - Generated WIDTH times.
- Top level holds:
  - priority decode to jk_register_op_e;
  - the incrementer;
  - the carry/overflow flops.

Test Plan:
- WIDTH=4, RESET_VALUE=4'b1010, reset_n pulsed low mid-cycle -> q_out=1010, carry_out=0 and overflow_out=0 immediately, before any clock edge.
- JK mode from 0000, one edge each with j/k:
  - j=1111,k=0000 -> 1111;
  - j=0000,k=0101 -> 1010;
  - j=1111,k=1111 -> 0101;
  - j=1111,k=1111 -> 1010;
  - j=0,k=0 -> 1010 (hold).
- load_in=1 with data_in=1110, then increment_in=1 for 3 edges:
  - q sequence 1110, 1111, 0000, 0001;
  - carry_out=1 only after the 1111->0000 edge;
  - overflow_out stays 1 afterwards.
- Priority: clear_in=load_in=increment_in=1, j=k=1111 with q=0110 -> q=0000, overflow_out cleared. Next edge load_in=increment_in=1, data_in=0011 -> q=0011 (load wins, no increment).
- Reset mid-operation: increment_in held 1 from q=0111, reset_n low for half a cycle spanning a rising edge -> q=RESET_VALUE; the suppressed edge does not increment. The next edge after release gives RESET_VALUE+1.
- WIDTH=1: increment_in from q=1 -> q=0, carry_out=1. JK j=1,k=1 toggles each edge: 1, 0, 1.
